// File: rtl/reg_bank_mp.sv
// rtl/reg_bank_mp.sv - parametrised multi-read-port register bank with post-reset clear sweep
//
// Registered, write-first register bank. After reset a sweep zeroes one entry
// per cycle; busy stays high until the sweep has covered every entry.
// Optional pending-write scoreboard enabled by defining REG_BANK_SCOREBOARD_EN.
//
// Ports:
//   clk       in   system clock, all state updates on posedge
//   rst       in   synchronous active-high reset
//   we        in   write enable
//   rw        in   write address
//   din       in   write data
//   ra        in   packed read addresses, port i at ra[i*ADDR_W +: ADDR_W]
//   dout      out  packed registered read data, port i at dout[i*DATA_W +: DATA_W]
//   busy      out  high while the clear sweep runs
//   pend_set  in   (REG_BANK_SCOREBOARD_EN) mark pend_addr as pending
//   pend_addr in   (REG_BANK_SCOREBOARD_EN) entry to mark pending
//   hazard    out  (REG_BANK_SCOREBOARD_EN) per-port pending flag, aligned with dout

module reg_bank_mp #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        rw,
    input  logic [DATA_W-1:0]        din,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] dout,
    output logic                     busy
`ifdef REG_BANK_SCOREBOARD_EN
    ,
    input  logic                     pend_set,
    input  logic [ADDR_W-1:0]        pend_addr,
    output logic [NUM_RD-1:0]        hazard
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDR_W-1:0]          ptr_q, ptr_d;
    logic                       busy_q, busy_d;
    logic [NUM_RD*DATA_W-1:0]   dout_q, dout_d;
    logic [DATA_W-1:0]          mem_q [DEPTH];

    logic                       mem_we;
    logic [ADDR_W-1:0]          mem_waddr;
    logic [DATA_W-1:0]          mem_wdata;
    logic                       wr_zero;

    // A write aimed at the hardwired-zero entry is dropped entirely.
    assign wr_zero = (ZERO_REG != 0) && (rw == '0);

    // Control FSM and the single storage write port, shared by the sweep and
    // normal writes so the array only ever sees one write per cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = rw;
        mem_wdata = din;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_ADDR) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                mem_we = we && !wr_zero;
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset: the sweep is what initialises it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Per-port read mux: zero entry, then same-cycle write bypass, then array.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        assign rd_addr = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            dout_d[g*DATA_W +: DATA_W] = '0;
            if (state_q == READY) begin
                if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                    dout_d[g*DATA_W +: DATA_W] = '0;
                end else if (we && (rw == rd_addr)) begin
                    dout_d[g*DATA_W +: DATA_W] = din;
                end else begin
                    dout_d[g*DATA_W +: DATA_W] = mem_q[rd_addr];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;
    assign busy = busy_q;

`ifdef REG_BANK_SCOREBOARD_EN
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [NUM_RD-1:0] hazard_q, hazard_d;

    // Set is applied after clear so a same-edge set on the written entry wins.
    always_comb begin
        pend_d = pend_q;
        if (state_q == READY) begin
            if (we) begin
                pend_d[rw] = 1'b0;
            end
            if (pend_set) begin
                pend_d[pend_addr] = 1'b1;
            end
        end
    end

    // Hazard sees this edge's clear but not its set: a same-cycle write is
    // covered by the bypass, a same-cycle set only shows on the next read.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_hz
        logic [ADDR_W-1:0] hz_addr;
        assign hz_addr = ra[g*ADDR_W +: ADDR_W];

        always_comb begin
            hazard_d[g] = 1'b0;
            if (state_q == READY && !((ZERO_REG != 0) && (hz_addr == '0))) begin
                hazard_d[g] = pend_q[hz_addr] && !(we && (rw == hz_addr));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            hazard_q <= '0;
        end else begin
            pend_q   <= pend_d;
            hazard_q <= hazard_d;
        end
    end

    assign hazard = hazard_q;
`endif

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb/tb_reg_bank_mp.sv - directed self-checking bench for reg_bank_mp

module tb_reg_bank_mp;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;

    logic                     clk;
    logic                     rst;
    logic                     we;
    logic [ADDR_W-1:0]        rw;
    logic [DATA_W-1:0]        din;
    logic [NUM_RD*ADDR_W-1:0] ra;
    logic [NUM_RD*DATA_W-1:0] dout;
    logic                     busy;
`ifdef REG_BANK_SCOREBOARD_EN
    logic                     pend_set;
    logic [ADDR_W-1:0]        pend_addr;
    logic [NUM_RD-1:0]        hazard;
`endif

    int checks;
    int failures;

    reg_bank_mp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .NUM_RD(NUM_RD),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we(we),
        .rw(rw),
        .din(din),
        .ra(ra),
        .dout(dout),
        .busy(busy)
`ifdef REG_BANK_SCOREBOARD_EN
        ,
        .pend_set(pend_set),
        .pend_addr(pend_addr),
        .hazard(hazard)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are stable 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] d0();
        return dout[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] d1();
        return dout[2*DATA_W-1:DATA_W];
    endfunction

    task automatic set_ra(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
        ra = {a1, a0};
    endtask

    // Counts edges after reset release until busy falls.
    task automatic count_busy(input string name, input bit late_write);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (late_write && n == 20) begin
                we = 1'b1; rw = 5'd3; din = 64'd99;
            end else begin
                we = 1'b0;
            end
            step();
            n++;
            if (busy === 1'b1) begin
                checks++;
                if (dout !== '0) begin
                    failures++;
                    $display("FAIL %s dout_during_sweep got=%h exp=0", name, dout);
                end
            end
        end
        we = 1'b0;
        checks++;
        if (n != 32) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=32", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; rw = '0; din = '0; set_ra(5'd3, 5'd17);
        step();
        checks++;
        if (busy !== 1'b1 || dout !== '0) begin
            failures++;
            $display("FAIL reset_state busy=%b dout=%h exp busy=1 dout=0", busy, dout);
        end
`ifdef REG_BANK_SCOREBOARD_EN
        checks++;
        if (hazard !== '0) begin
            failures++;
            $display("FAIL reset_hazard got=%b exp=0", hazard);
        end
`endif
        step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_held busy=%b exp=1", busy);
        end
        rst = 1'b0;
        // Write during the sweep, after the sweep has already passed entry 3.
        count_busy("sweep", 1'b1);
    endtask

    task automatic test_all_zero();
        for (int a = 0; a < 32; a++) begin
            set_ra(ADDR_W'(a), ADDR_W'(31 - a));
            step();
            checks++;
            if (d0() !== '0 || d1() !== '0) begin
                failures++;
                $display("FAIL zero_after_sweep addr=%0d got0=%h got1=%h exp=0", a, d0(), d1());
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_sweep_busy got=%b exp=1", busy);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("restart", 1'b0);
        set_ra(5'd3, 5'd3);
        step();
        checks++;
        if (d0() !== '0) begin
            failures++;
            $display("FAIL busy_write_ignored got=%h exp=0", d0());
        end
    endtask

    task automatic test_write_read();
        we = 1'b1; rw = 5'd5; din = 64'hFFFF_FFFF_FFFF_FFD3;
        set_ra(5'd1, 5'd2);
        step();
        we = 1'b1; rw = 5'd31; din = 64'h8000_0000_0000_0001;
        set_ra(5'd5, 5'd5);
        step();
        checks++;
        if (d0() !== 64'hFFFF_FFFF_FFFF_FFD3 || d1() !== 64'hFFFF_FFFF_FFFF_FFD3) begin
            failures++;
            $display("FAIL write_read_x5 got0=%h got1=%h exp=ffffffffffffffd3", d0(), d1());
        end
        we = 1'b0;
        set_ra(5'd5, 5'd31);
        step();
        checks++;
        if (d0() !== 64'hFFFF_FFFF_FFFF_FFD3 || d1() !== 64'h8000_0000_0000_0001) begin
            failures++;
            $display("FAIL write_read_x31 got0=%h got1=%h exp0=ffffffffffffffd3 exp1=8000000000000001", d0(), d1());
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; rw = 5'd7; din = 64'd36;
        set_ra(5'd7, 5'd5);
        step();
        checks++;
        if (d0() !== 64'd36 || d1() !== 64'hFFFF_FFFF_FFFF_FFD3) begin
            failures++;
            $display("FAIL bypass_x7 got0=%h got1=%h exp0=24 exp1=ffffffffffffffd3", d0(), d1());
        end
        we = 1'b1; rw = 5'd0; din = 64'd11;
        set_ra(5'd0, 5'd7);
        step();
        checks++;
        if (d0() !== '0 || d1() !== 64'd36) begin
            failures++;
            $display("FAIL x0_bypass got0=%h got1=%h exp0=0 exp1=24", d0(), d1());
        end
        we = 1'b0;
        set_ra(5'd0, 5'd0);
        step();
        checks++;
        if (d0() !== '0 || d1() !== '0) begin
            failures++;
            $display("FAIL x0_stored got0=%h got1=%h exp=0", d0(), d1());
        end
    endtask

    task automatic test_back_to_back();
        logic [DATA_W-1:0] exp_prev;
        exp_prev = '0;
        for (int i = 0; i < 4; i++) begin
            we = 1'b1; rw = ADDR_W'(10 + i); din = 64'(i * 1000 + 7);
            set_ra(ADDR_W'(10 + i), ADDR_W'(9 + i));
            step();
            checks++;
            if (d0() !== 64'(i * 1000 + 7) || d1() !== exp_prev) begin
                failures++;
                $display("FAIL back_to_back i=%0d got0=%h got1=%h exp0=%h exp1=%h",
                         i, d0(), d1(), 64'(i * 1000 + 7), exp_prev);
            end
            exp_prev = 64'(i * 1000 + 7);
        end
        we = 1'b0;
    endtask

`ifdef REG_BANK_SCOREBOARD_EN
    task automatic test_scoreboard();
        pend_set = 1'b1; pend_addr = 5'd4; we = 1'b0;
        set_ra(5'd1, 5'd2);
        step();
        pend_set = 1'b1; pend_addr = 5'd0;
        set_ra(5'd4, 5'd0);
        step();
        checks++;
        if (hazard !== 2'b01 || d0() !== '0) begin
            failures++;
            $display("FAIL sb_pending hazard=%b dout0=%h exp hazard=01 dout0=0", hazard, d0());
        end
        pend_set = 1'b0;
        we = 1'b1; rw = 5'd4; din = 64'd2;
        set_ra(5'd4, 5'd0);
        step();
        checks++;
        if (hazard[0] !== 1'b0 || d0() !== 64'd2) begin
            failures++;
            $display("FAIL sb_write_clears hazard0=%b dout0=%h exp hazard0=0 dout0=2", hazard[0], d0());
        end
        we = 1'b0;
        step();
        checks++;
        if (hazard[0] !== 1'b0) begin
            failures++;
            $display("FAIL sb_cleared hazard0=%b exp=0", hazard[0]);
        end
        pend_set = 1'b1; pend_addr = 5'd4;
        we = 1'b1; rw = 5'd4; din = 64'd5;
        step();
        checks++;
        if (hazard[0] !== 1'b0 || d0() !== 64'd5) begin
            failures++;
            $display("FAIL sb_same_edge hazard0=%b dout0=%h exp hazard0=0 dout0=5", hazard[0], d0());
        end
        pend_set = 1'b0; we = 1'b0;
        step();
        checks++;
        if (hazard[0] !== 1'b1) begin
            failures++;
            $display("FAIL sb_set_wins hazard0=%b exp=1", hazard[0]);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (hazard !== '0) begin
            failures++;
            $display("FAIL sb_reset hazard=%b exp=0", hazard);
        end
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
`ifdef REG_BANK_SCOREBOARD_EN
        pend_set = 1'b0;
        pend_addr = '0;
`endif
        test_reset();
        test_all_zero();
        test_reset_mid_sweep();
        test_write_read();
        test_bypass();
        test_back_to_back();
`ifdef REG_BANK_SCOREBOARD_EN
        test_scoreboard();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
